sound_cmd_mailbox: RTL and testbench

Bidirectional command/reply mailbox between the main 6809 and the sound 6809. It is the receiving end of the main CPU's sound-command writes ($4400) and the source of the sound-board reply and handshake flags ($4400 read, $4401 status). It holds a command FIFO (main to sound) and a single reply latch (sound to main), and drives the handshake flags both CPUs poll. Everything runs in the clk_12 domain; both CPU buses present single-cycle access strobes.

---
 rtl/sound_cmd_mailbox_if.sv | 22 ++
 rtl/sound_cmd_mailbox.sv | 75 +++++++
 tb/tb_sound_cmd_mailbox.sv | 118 +++++++++++
 3 files changed

// File: rtl/sound_cmd_mailbox_if.sv
// sound_cmd_mailbox_if: main/sound CPU strobes and data for the command/reply mailbox
interface sound_cmd_mailbox_if;
  logic       main_wr;
  logic [7:0] main_data_in;
  logic       main_rd;
  logic [7:0] main_data_out;
  logic [7:0] main_status;
  logic       sound_rd;
  logic [7:0] sound_data_out;
  logic       sound_wr;
  logic [7:0] sound_data_in;
  logic [7:0] sound_status;
  logic       sound_irq;
  modport master (
    output main_wr, main_data_in, main_rd, sound_rd, sound_wr, sound_data_in,
    input  main_data_out, main_status, sound_data_out, sound_status, sound_irq
  );
  modport slave (
    input  main_wr, main_data_in, main_rd, sound_rd, sound_wr, sound_data_in,
    output main_data_out, main_status, sound_data_out, sound_status, sound_irq
  );
endinterface

// File: rtl/sound_cmd_mailbox.sv
// sound_cmd_mailbox: main-to-sound command FIFO plus sound-to-main reply latch with handshake flags
module sound_cmd_mailbox #(
  parameter int CMD_DEPTH = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk_12,
  input  logic             reset_n,
  input  logic             sync_clr,
  sound_cmd_mailbox_if.slave bus,
  output logic [CNT_W-1:0] cmd_ovr_cnt,
  output logic [CNT_W-1:0] reply_ovr_cnt
);
  localparam int AW = CMD_DEPTH > 1 ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(CMD_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(CMD_DEPTH);
  logic [7:0]    mem [CMD_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    reply;
  logic          reply_full, cmd_ovr, reply_ovr;
  logic          cmd_full, cmd_avail, pop, push, cmd_drop, reply_drop;
  always_comb begin
    cmd_full   = count == FULL;
    cmd_avail  = count != '0;
    pop        = bus.sound_rd && cmd_avail;
    push       = bus.main_wr && (!cmd_full || pop);
    cmd_drop   = bus.main_wr && cmd_full && !pop;
    reply_drop = bus.sound_wr && reply_full && !bus.main_rd;
  end
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) mem[i] <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      reply         <= '0;
      reply_full    <= 1'b0;
      cmd_ovr       <= 1'b0;
      reply_ovr     <= 1'b0;
      cmd_ovr_cnt   <= '0;
      reply_ovr_cnt <= '0;
    end else if (sync_clr) begin
      for (int i = 0; i < CMD_DEPTH; i++) mem[i] <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      reply         <= '0;
      reply_full    <= 1'b0;
      cmd_ovr       <= 1'b0;
      reply_ovr     <= 1'b0;
      cmd_ovr_cnt   <= '0;
      reply_ovr_cnt <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      if (push) begin
        mem[wr_ptr] <= bus.main_data_in;
        wr_ptr      <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      // a new overrun in the same cycle as the clearing read stays visible
      cmd_ovr   <= cmd_drop || (cmd_ovr && !bus.main_rd);
      reply_ovr <= reply_drop || (reply_ovr && !bus.main_rd);
      if (cmd_drop && !(&cmd_ovr_cnt)) cmd_ovr_cnt <= cmd_ovr_cnt + 1'b1;
      if (reply_drop && !(&reply_ovr_cnt)) reply_ovr_cnt <= reply_ovr_cnt + 1'b1;
      if (bus.sound_wr) reply <= bus.sound_data_in;
      reply_full <= bus.sound_wr || (reply_full && !bus.main_rd);
    end
  end
  assign bus.main_data_out  = reply;
  assign bus.main_status    = {reply_full, cmd_full, 4'b0, reply_ovr, cmd_ovr};
  assign bus.sound_data_out = mem[rd_ptr];
  assign bus.sound_status   = {cmd_avail, reply_full, 6'b0};
  assign bus.sound_irq      = cmd_avail;
endmodule

// File: tb/tb_sound_cmd_mailbox.sv
// tb_sound_cmd_mailbox: table-driven check of the mailbox at CMD_DEPTH 1 and 4
module tb_sound_cmd_mailbox;
  typedef struct {
    bit d4, clr, mwr, mrd, srd, swr;
    logic [7:0] md, sd, mdo, ms, sdo, ss;
    logic irq;
    logic [7:0] cov, rov;
  } vec_t;
  logic clk_12 = 1'b0;
  logic reset_n, clr1, clr4;
  logic [7:0] c1, r1, c4, r4;
  int nvec = 0, nerr = 0;
  vec_t tv[$];
  always #5 clk_12 = ~clk_12;
  sound_cmd_mailbox_if a1();
  sound_cmd_mailbox_if a4();
  sound_cmd_mailbox #(.CMD_DEPTH(1), .CNT_W(8)) dut1 (
    .clk_12(clk_12), .reset_n(reset_n), .sync_clr(clr1), .bus(a1.slave),
    .cmd_ovr_cnt(c1), .reply_ovr_cnt(r1));
  sound_cmd_mailbox #(.CMD_DEPTH(4), .CNT_W(8)) dut4 (
    .clk_12(clk_12), .reset_n(reset_n), .sync_clr(clr4), .bus(a4.slave),
    .cmd_ovr_cnt(c4), .reply_ovr_cnt(r4));
  function automatic vec_t mk(bit d4, bit clr, bit mwr, bit mrd, bit srd, bit swr,
                              logic [7:0] md, logic [7:0] sd, logic [7:0] mdo, logic [7:0] ms,
                              logic [7:0] sdo, logic [7:0] ss, logic irq, logic [7:0] cov,
                              logic [7:0] rov);
    vec_t v;
    v = '{d4, clr, mwr, mrd, srd, swr, md, sd, mdo, ms, sdo, ss, irq, cov, rov};
    return v;
  endfunction
  function automatic logic [48:0] got(bit d4);
    return d4 ? {a4.main_data_out, a4.main_status, a4.sound_data_out, a4.sound_status, a4.sound_irq, c4, r4}
              : {a1.main_data_out, a1.main_status, a1.sound_data_out, a1.sound_status, a1.sound_irq, c1, r1};
  endfunction
  task automatic idle();
    {a1.main_wr, a1.main_rd, a1.sound_rd, a1.sound_wr, clr1} = '0;
    {a4.main_wr, a4.main_rd, a4.sound_rd, a4.sound_wr, clr4} = '0;
    {a1.main_data_in, a1.sound_data_in, a4.main_data_in, a4.sound_data_in} = '0;
  endtask
  task automatic drive(vec_t v);
    idle();
    if (v.d4) begin
      {clr4, a4.main_wr, a4.main_rd, a4.sound_rd, a4.sound_wr} = {v.clr, v.mwr, v.mrd, v.srd, v.swr};
      a4.main_data_in  = v.md;
      a4.sound_data_in = v.sd;
    end else begin
      {clr1, a1.main_wr, a1.main_rd, a1.sound_rd, a1.sound_wr} = {v.clr, v.mwr, v.mrd, v.srd, v.swr};
      a1.main_data_in  = v.md;
      a1.sound_data_in = v.sd;
    end
  endtask
  task automatic check(string name, logic [48:0] act, logic [48:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    // CMD_DEPTH=1, fields: d4 clr mwr mrd srd swr | md sd | mdo ms sdo ss irq cov rov
    tv.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00,0,8'd0,8'd0));
    tv.push_back(mk(0,0,1,0,0,0, 8'hA5,8'h00, 8'h00,8'h40,8'hA5,8'h80,1,8'd0,8'd0));
    tv.push_back(mk(0,0,0,0,1,0, 8'h00,8'h00, 8'h00,8'h00,8'hA5,8'h00,0,8'd0,8'd0));
    tv.push_back(mk(0,0,0,0,1,0, 8'h00,8'h00, 8'h00,8'h00,8'hA5,8'h00,0,8'd0,8'd0));
    tv.push_back(mk(0,0,1,0,0,0, 8'h11,8'h00, 8'h00,8'h40,8'h11,8'h80,1,8'd0,8'd0));
    tv.push_back(mk(0,0,1,0,0,0, 8'h22,8'h00, 8'h00,8'h41,8'h11,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(0,0,1,0,1,0, 8'h33,8'h00, 8'h00,8'h41,8'h33,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(0,0,0,0,0,1, 8'h00,8'h5A, 8'h5A,8'hC1,8'h33,8'hC0,1,8'd1,8'd0));
    tv.push_back(mk(0,0,0,0,0,1, 8'h00,8'hC3, 8'hC3,8'hC3,8'h33,8'hC0,1,8'd1,8'd1));
    tv.push_back(mk(0,0,0,1,0,1, 8'h00,8'h99, 8'h99,8'hC0,8'h33,8'hC0,1,8'd1,8'd1));
    tv.push_back(mk(0,0,0,1,0,0, 8'h00,8'h00, 8'h99,8'h40,8'h33,8'h80,1,8'd1,8'd1));
    tv.push_back(mk(0,0,1,1,0,0, 8'h44,8'h00, 8'h99,8'h41,8'h33,8'h80,1,8'd2,8'd1));
    tv.push_back(mk(0,1,1,0,0,0, 8'h77,8'h00, 8'h00,8'h00,8'h00,8'h00,0,8'd0,8'd0));
    tv.push_back(mk(0,0,1,0,1,0, 8'h77,8'h00, 8'h00,8'h40,8'h77,8'h80,1,8'd0,8'd0));
    // CMD_DEPTH=4
    tv.push_back(mk(1,0,1,0,0,0, 8'h01,8'h00, 8'h00,8'h00,8'h01,8'h80,1,8'd0,8'd0));
    tv.push_back(mk(1,0,1,0,0,0, 8'h02,8'h00, 8'h00,8'h00,8'h01,8'h80,1,8'd0,8'd0));
    tv.push_back(mk(1,0,1,0,0,0, 8'h03,8'h00, 8'h00,8'h00,8'h01,8'h80,1,8'd0,8'd0));
    tv.push_back(mk(1,0,1,0,0,0, 8'h04,8'h00, 8'h00,8'h40,8'h01,8'h80,1,8'd0,8'd0));
    tv.push_back(mk(1,0,1,0,0,0, 8'h05,8'h00, 8'h00,8'h41,8'h01,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(1,0,0,0,1,0, 8'h00,8'h00, 8'h00,8'h01,8'h02,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(1,0,0,0,1,0, 8'h00,8'h00, 8'h00,8'h01,8'h03,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(1,0,0,0,1,0, 8'h00,8'h00, 8'h00,8'h01,8'h04,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(1,0,0,0,1,0, 8'h00,8'h00, 8'h00,8'h01,8'h01,8'h00,0,8'd1,8'd0));
    tv.push_back(mk(1,0,1,0,0,0, 8'h06,8'h00, 8'h00,8'h01,8'h06,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(1,0,0,1,0,0, 8'h00,8'h00, 8'h00,8'h00,8'h06,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(1,0,1,0,0,0, 8'h07,8'h00, 8'h00,8'h00,8'h06,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(1,0,1,0,0,0, 8'h08,8'h00, 8'h00,8'h00,8'h06,8'h80,1,8'd1,8'd0));
    tv.push_back(mk(1,0,1,0,0,0, 8'h09,8'h00, 8'h00,8'h40,8'h06,8'h80,1,8'd1,8'd0));
    idle();
    reset_n = 1'b0;
    #12 reset_n = 1'b1;
    foreach (tv[i]) begin
      @(negedge clk_12);
      drive(tv[i]);
      @(posedge clk_12);
      #1 check($sformatf("vec%0d", i), got(tv[i].d4),
               {tv[i].mdo, tv[i].ms, tv[i].sdo, tv[i].ss, tv[i].irq, tv[i].cov, tv[i].rov});
    end
    @(negedge clk_12);
    idle();
    // hold main_wr on the full depth-4 FIFO: every cycle is a dropped write
    a4.main_wr      = 1'b1;
    a4.main_data_in = 8'hAA;
    repeat (300) @(posedge clk_12);
    @(negedge clk_12);
    idle();
    #1 check("cnt_saturate", got(1), {8'h00, 8'h41, 8'h06, 8'h80, 1'b1, 8'hFF, 8'h00});
    @(negedge clk_12);
    #2 reset_n = 1'b0;
    #1 check("async_reset_d1", got(0), '0);
    check("async_reset_d4", got(1), '0);
    #3 reset_n = 1'b1;
    repeat (2) @(posedge clk_12);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
